// File: rtl/max_finder.sv
// Streaming arg-max over NUM_CLASS signed scores per frame; result registered one cycle after the last score.
// Define MAX_FINDER_MARGIN_EN to also track the runner-up score and drive the top-1 minus top-2 margin.
module max_finder #(
  parameter int NUM_CLASS = 10,
  parameter int CNT_BITS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_in,
  input  logic signed [11:0]         in_data,
  output logic        [CNT_BITS-1:0] decision,
  output logic signed [11:0]         max_score,
  output logic        [12:0]         margin,
  output logic                       valid_out,
  output logic                       busy
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

  localparam logic [CNT_BITS-1:0] LastIdx  = CNT_BITS'(NUM_CLASS - 1);
  localparam logic signed [11:0]  MinScore = -12'sd2048;

  state_e                    state_q, state_d;
  logic [CNT_BITS-1:0]       cnt_q, cnt_d;
  logic signed [11:0]        bestVal_q, bestVal_d;
  logic [CNT_BITS-1:0]       bestIdx_q, bestIdx_d;
  logic [CNT_BITS-1:0]       decision_q, decision_d;
  logic signed [11:0]        maxScore_q, maxScore_d;
  logic                      validOut_q, validOut_d;
  logic                      frameDone;

`ifdef MAX_FINDER_MARGIN_EN
  logic signed [11:0]        secondVal_q, secondVal_d;
  logic [12:0]               margin_q, margin_d;
`endif

  // Next-state logic: strict '>' keeps the earliest class on ties.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bestVal_d = bestVal_q;
    bestIdx_d = bestIdx_q;
    frameDone = 1'b0;
`ifdef MAX_FINDER_MARGIN_EN
    secondVal_d = secondVal_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          bestVal_d = in_data;
          bestIdx_d = '0;
          cnt_d     = CNT_BITS'(1);
          state_d   = COLLECT;
`ifdef MAX_FINDER_MARGIN_EN
          secondVal_d = MinScore;
`endif
        end
      end
      COLLECT: begin
        if (valid_in) begin
          if (in_data > bestVal_q) begin
            bestVal_d = in_data;
            bestIdx_d = cnt_q;
`ifdef MAX_FINDER_MARGIN_EN
            secondVal_d = bestVal_q;
`endif
          end else begin
`ifdef MAX_FINDER_MARGIN_EN
            if (in_data > secondVal_q) begin
              secondVal_d = in_data;
            end
`endif
          end
          if (cnt_q == LastIdx) begin
            cnt_d     = '0;
            state_d   = IDLE;
            frameDone = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Result registers capture the updated best values only when a frame closes.
  always_comb begin
    validOut_d = frameDone;
    decision_d = decision_q;
    maxScore_d = maxScore_q;
`ifdef MAX_FINDER_MARGIN_EN
    margin_d = margin_q;
`endif
    if (frameDone) begin
      decision_d = bestIdx_d;
      maxScore_d = bestVal_d;
`ifdef MAX_FINDER_MARGIN_EN
      margin_d = {bestVal_d[11], bestVal_d} - {secondVal_d[11], secondVal_d};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bestVal_q  <= '0;
      bestIdx_q  <= '0;
      decision_q <= '0;
      maxScore_q <= '0;
      validOut_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bestVal_q  <= bestVal_d;
      bestIdx_q  <= bestIdx_d;
      decision_q <= decision_d;
      maxScore_q <= maxScore_d;
      validOut_q <= validOut_d;
    end
  end

`ifdef MAX_FINDER_MARGIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      secondVal_q <= MinScore;
      margin_q    <= '0;
    end else begin
      secondVal_q <= secondVal_d;
      margin_q    <= margin_d;
    end
  end

  assign margin = margin_q;
`else
  assign margin = 13'd0;
`endif

  assign decision  = decision_q;
  assign max_score = maxScore_q;
  assign valid_out = validOut_q;
  assign busy      = (state_q == COLLECT);

endmodule
